// File: rtl/fetch_queue.sv
// Instruction prefetch queue. It fetches one word per cycle from instruction memory into a
// small FIFO and hands the entries to the IF/ID register. A redirect flushes the queue and restarts the fetch.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [15:0]              imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     halt,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [15:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [15:0] STEP = 16'(PC_STEP);

    logic [15:0]   fetchPc;
    logic [AW-1:0] headPtr;
    logic [AW-1:0] tailPtr;
    logic [AW:0]   occupancy;
    logic [31:0]   instrMem [DEPTH];
    logic [15:0]   pcMem    [DEPTH];
    logic          notEmpty;
    logic          push;
    logic          pop;

    assign imem_addr = fetchPc;
    assign count     = occupancy;
    assign notEmpty  = (occupancy != '0);

    // A redirect hides the head in the same cycle so that a stale instruction is never consumed.
    assign out_valid = notEmpty && !redirect;
    assign out_instr = notEmpty ? instrMem[headPtr] : 32'h0;
    assign out_pc    = notEmpty ? pcMem[headPtr]    : 16'h0;

    assign pop  = out_valid && out_ready;
    assign push = !halt && !redirect && ((occupancy < FULL) || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc   <= RESET_PC;
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
        end else if (redirect) begin
            fetchPc   <= redirect_pc;
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                fetchPc <= fetchPc + STEP;
                tailPtr <= tailPtr + 1'b1;
            end
            if (pop) begin
                headPtr <= headPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage carries no reset. Its contents are only visible through the occupancy.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            instrMem[tailPtr] <= imem_data;
            pcMem[tailPtr]    <= fetchPc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue. It compares the DUT every cycle against a
// queue-based model of the prefetch behaviour.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] STEP     = 16'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(1)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordAt(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    assign imem_data = wordAt(imem_addr);

    typedef struct packed { logic [15:0] pc; logic [31:0] instr; } entry_t;
    entry_t      mq[$];
    logic [15:0] mPc;
    int          nChecks = 0;
    int          nPass   = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic checkAll();
        logic        eValid;
        logic [15:0] ePc;
        logic [31:0] eInstr;
        eValid = (mq.size() > 0) && !redirect;
        ePc    = (mq.size() > 0) ? mq[0].pc : 16'h0;
        eInstr = (mq.size() > 0) ? mq[0].instr : 32'h0;
        checkVal("out_valid", 32'(out_valid), 32'(eValid));
        checkVal("out_pc",    32'(out_pc),    32'(ePc));
        checkVal("out_instr", out_instr,      eInstr);
        checkVal("count",     32'(count),     32'(mq.size()));
        checkVal("imem_addr", 32'(imem_addr), 32'(mPc));
    endtask

    // Applies the effect of the coming rising edge to the model, using the current inputs.
    task automatic modelEdge();
        bit doPop, doPush;
        if (redirect) begin
            mq.delete();
            mPc = redirect_pc;
        end else begin
            doPop  = (mq.size() > 0) && out_ready;
            doPush = !halt && ((mq.size() < DEPTH) || doPop);
            if (doPop) void'(mq.pop_front());
            if (doPush) begin
                mq.push_back({mPc, wordAt(mPc)});
                mPc = mPc + STEP;
            end
        end
    endtask

    // Called at a falling edge. Returns at the next falling edge.
    task automatic step(input logic h, input logic r, input logic [15:0] rpc, input logic rdy);
        halt = h; redirect = r; redirect_pc = rpc; out_ready = rdy;
        #1;
        checkAll();
        modelEdge();
        @(negedge clk);
    endtask

    task automatic asyncReset();
        halt = 1'b0; redirect = 1'b0; out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkVal("rst_valid", 32'(out_valid), 32'd0);
        checkVal("rst_count", 32'(count),     32'd0);
        checkVal("rst_addr",  32'(imem_addr), 32'(RESET_PC));
        checkVal("rst_pc",    32'(out_pc),    32'd0);
        checkVal("rst_instr", out_instr,      32'd0);
        #1 rst = 1'b1;
        mq.delete();
        mPc = RESET_PC;
        modelEdge();
        @(negedge clk);
    endtask

    initial begin
        mPc = RESET_PC;
        @(negedge clk);
        @(negedge clk);
        checkVal("init_valid", 32'(out_valid), 32'd0);
        checkVal("init_count", 32'(count),     32'd0);
        checkVal("init_addr",  32'(imem_addr), 32'(RESET_PC));
        rst = 1'b1;

        // Streaming from reset release, with one word per cycle.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Backpressure: the queue fills, the fetch address holds, and the entries then drain in order.
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        checkVal("full_count", 32'(count),     32'd4);
        checkVal("full_addr",  32'(imem_addr), 32'h0004);
        checkVal("full_head",  32'(out_pc),    32'h0000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect with 3 entries queued.
        step(1'b0, 1'b1, 16'h0040, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        checkVal("three_count", 32'(count), 32'd3);
        step(1'b0, 1'b1, 16'h0100, 1'b1);
        checkVal("redir_addr", 32'(imem_addr), 32'h0100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // The fetch address wraps at the top of the 16-bit space.
        step(1'b0, 1'b1, 16'hFFFE, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Halt with 2 entries queued: the queue drains, and fetch then resumes at the frozen address.
        step(1'b0, 1'b1, 16'h0200, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
        checkVal("halt_addr", 32'(imem_addr), 32'h0202);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Asynchronous reset mid-operation with 3 entries queued.
        step(1'b0, 1'b1, 16'h0300, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        asyncReset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic        h, r, rdy;
            logic [15:0] rpc;
            h   = ($urandom_range(0, 99) < 20);
            r   = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 70);
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                              : 16'($urandom);
            step(h, r, rpc, rdy);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
